// File: rtl/program_memory.sv
// DEPTH x 8 CPU program store with power-up clear sequencer and host load port; 1-cycle registered write-first read.
// Host bytes accepted whenever ld_ready is high; the CPU is held in reset (cpu_rst_n=0) while clearing or loading.
module program_memory #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4096,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [7:0]        M_data_out,
  input  logic              Write_read,
  output logic [7:0]        M_data_in,
  output logic              cpu_rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_wrap
);

  typedef enum logic [1:0] {CLEAR, RUN, LOAD, RELEASE} state_t;

  localparam state_t            RST_STATE = CLEAR_EN ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [7:0]        mem [DEPTH];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_addr, ld_addr;
  logic              run, ld_beat;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_dat;

  assign run      = (state == RUN);
  assign ld_ready = (state == LOAD);
  assign ld_beat  = ld_ready & ld_valid;

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_addr == LAST_ADDR) state_nx = RELEASE;
      RELEASE: state_nx = RUN;
      RUN:     if (ld_start) state_nx = LOAD;
      LOAD:    if (ld_beat && ld_last) state_nx = RELEASE;
      default: state_nx = RST_STATE;
    endcase
  end

  // Single shared write port: clear, host load and CPU writes are mutually exclusive by state.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = M_addr;
    wr_dat  = M_data_out;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_dat  = 8'h00;
    end else if (ld_beat) begin
      wr_en   = 1'b1;
      wr_addr = ld_addr;
      wr_dat  = ld_data;
    end else if (run && Write_read) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_data_in <= 8'h00;
    end else if (run) begin
      M_data_in <= Write_read ? M_data_out : mem[M_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_STATE;
      clr_addr  <= '0;
      ld_addr   <= '0;
      ld_wrap   <= 1'b0;
      ld_done   <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_nx;
      ld_done   <= ld_beat & ld_last;
      // CPU leaves reset on the edge that enters RUN and re-enters it on the edge that leaves RUN.
      cpu_rst_n <= (state_nx == RUN);
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (run && ld_start) begin
        ld_addr <= ld_base;
        ld_wrap <= 1'b0;
      end else if (ld_beat) begin
        ld_addr <= ld_addr + 1'b1;
        if (ld_addr == LAST_ADDR) ld_wrap <= 1'b1;
      end
    end
  end

endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Memory responder on the CPU's 12-bit address / 8-bit data bus: a DEPTH x 8 byte store that serves instruction fetches and Read/Write operands.
- Includes a clear sequencer and a host program-load port.
- Holds the CPU in reset (cpu_rst_n low) while memory is being cleared or loaded.
- Sits between the top-level host/testbench loader and the CPU core.

Parameters:
ADDR_W, 12, address width; must match the CPU M_addr width
DEPTH, 4096, number of bytes; equals 2**ADDR_W
CLEAR_EN, 1, 1 = zero-fill all memory after reset; 0 = skip straight to RUN

Ports:
clk  in  1  system clock; all state changes occur on the rising edge
reset  in  1  asynchronous, active-low reset
M_addr  in  ADDR_W  CPU byte address
M_data_out  in  8  write data from the CPU
Write_read  in  1  1 = CPU write, 0 = CPU read
M_data_in  out  8  read data to the CPU
cpu_rst_n  out  1  active-low reset to the CPU core
ld_start  in  1  one-cycle pulse that begins a program load
ld_base  in  ADDR_W  load start address, sampled with ld_start
ld_valid  in  1  host byte valid
ld_data  in  8  host byte
ld_last  in  1  marks the final byte of the load; qualified by ld_valid
ld_ready  out  1  block accepts a byte this cycle
ld_done  out  1  one-cycle pulse after the final byte is written
ld_wrap  out  1  sticky flag: the load address wrapped from DEPTH-1 to 0

Behaviour:
- Async reset (reset=0):
  - state=CLEAR if CLEAR_EN=1, else RUN.
  - clr_addr=0, ld_addr=0.
  - M_data_in=0, cpu_rst_n=0, ld_ready=0, ld_done=0, ld_wrap=0.
  - Array contents are not reset.
- States: CLEAR, RUN, LOAD, RELEASE.
- CLEAR:
  - Each cycle writes 0 to mem[clr_addr], then clr_addr++.
  - When clr_addr=DEPTH-1 is written, go to RELEASE. Takes exactly DEPTH cycles.
  - CPU bus and ld_start are ignored.
- RELEASE:
  - One cycle with cpu_rst_n still 0, then go to RUN.
  - cpu_rst_n rises on the edge that enters RUN.
- RUN:
  - cpu_rst_n=1.
  - Every rising edge: if Write_read=1, mem[M_addr] <= M_data_out.
  - Every rising edge: M_data_in <= mem[M_addr] (1-cycle registered read).
  - Write-first: a write and a read to the same address in the same cycle return the new data.
  - ld_start=1 goes to LOAD:
    - ld_addr <= ld_base, ld_wrap <= 0.
    - cpu_rst_n <= 0 on the same edge.
    - The CPU access on that edge still completes.
- LOAD:
  - ld_ready=1; CPU bus ignored, CPU writes dropped; M_data_in holds its last value.
  - On ld_valid & ld_ready: mem[ld_addr] <= ld_data, then ld_addr++.
  - At DEPTH-1 the address wraps to 0 and sets ld_wrap, which stays set until the next ld_start or reset.
  - If that beat has ld_last=1: go to RELEASE, ld_ready drops next cycle, ld_done=1 for exactly one cycle (the RELEASE cycle).
  - ld_valid=0 cycles are stalls with no write and no timeout.
  - ld_start during LOAD is ignored.
- ld_start in CLEAR or RELEASE is ignored, not queued.
- Reset mid-CLEAR or mid-LOAD:
  - Restarts at CLEAR (or RUN if CLEAR_EN=0).
  - Partially loaded bytes are lost if CLEAR_EN=1 and retained otherwise.
- All address arithmetic is modulo DEPTH; M_addr is always in range since DEPTH=2**ADDR_W.

Test Plan:
- Reset with CLEAR_EN=1 -> cpu_rst_n=0 for DEPTH+1 cycles after reset release (4097 with defaults), then 1; a CPU read of 0xABC returns 0x00.
- RUN: write 0x5A to 0x123 with Write_read=1, then a read of 0x123 -> M_data_in=0x5A one cycle later; a same-cycle write 0x77 plus read of 0x124 -> M_data_in=0x77 (write-first).
- Load with ld_base=0x010, bytes 0x1A,0x2B,0x3C, ld_last on 0x3C, two ld_valid=0 stall cycles inserted -> mem[0x010..0x012]=1A,2B,3C; ld_done pulses once; cpu_rst_n returns to 1 exactly 2 cycles after the last beat; ld_wrap=0.
- Load with ld_base=0xFFE, 4 bytes -> mem[0xFFE],[0xFFF],[0x000],[0x001] written; ld_wrap=1 and stays 1 in RUN until the next ld_start.
- During LOAD, drive Write_read=1, M_addr=0x010, M_data_out=0xEE -> mem[0x010] unchanged; a second ld_start mid-load has no effect.
- Assert reset after 2 of 4 load bytes with CLEAR_EN=0 -> state RUN, cpu_rst_n=0 during reset then 1 after release (no RELEASE cycle when CLEAR_EN=0), the 2 written bytes retained, ld_ready=0, ld_done never pulses.
